// File: rtl/fft_butterfly_pipe_if.sv
// rtl/fft_butterfly_pipe_if.sv - handshake and data bundle for the radix-2 butterfly
//
// Purpose: groups the input triple, the output pair and both valid/ready
// handshakes of fft_butterfly_pipe into one bundle.
// Ports (signals):
//   in_valid/in_ready     input-side handshake
//   a_in, b_in, w_in      operands and twiddle, {re,im}, re in the upper DW bits
//   bypass, scale         per-sample controls, travel with the sample
//   out_valid/out_ready   output-side handshake
//   x0_out, x1_out        A + W*B and A - W*B, {re,im}
// Modports: master drives the inputs and out_ready, slave is the butterfly.
interface fft_butterfly_pipe_if #(
  parameter int DW = 16
);
  logic            in_valid;
  logic            in_ready;
  logic [2*DW-1:0] a_in;
  logic [2*DW-1:0] b_in;
  logic [2*DW-1:0] w_in;
  logic            bypass;
  logic            scale;
  logic            out_valid;
  logic            out_ready;
  logic [2*DW-1:0] x0_out;
  logic [2*DW-1:0] x1_out;

  modport master (
    output in_valid, a_in, b_in, w_in, bypass, scale, out_ready,
    input  in_ready, out_valid, x0_out, x1_out
  );

  modport slave (
    input  in_valid, a_in, b_in, w_in, bypass, scale, out_ready,
    output in_ready, out_valid, x0_out, x1_out
  );
endinterface

// File: rtl/fft_butterfly_pipe.sv
// rtl/fft_butterfly_pipe.sv - pipelined radix-2 DIT butterfly with scaling and saturation
//
// Purpose: four-stage butterfly computing X0 = A + W*B and X1 = A - W*B on
// signed fixed-point complex samples, with optional twiddle bypass, optional
// 1/2 output scaling (round half up), output saturation and overflow reporting.
// Ports:
//   clk         clock, rising edge
//   reset       synchronous, active-high
//   bus         fft_butterfly_pipe_if slave: input triple + controls, output pair
//   ovf_clr     clears ovf_sticky and ovf_cnt (wins over a same-cycle overflow)
//   ovf_sticky  a saturation happened since reset or the last ovf_clr
//   ovf_cnt     saturating count of output samples that saturated
module fft_butterfly_pipe #(
  parameter int DW     = 16,
  parameter int FRAC   = 8,
  parameter int OVF_CW = 8
) (
  input  logic              clk,
  input  logic              reset,
  fft_butterfly_pipe_if.slave bus,
  input  logic              ovf_clr,
  output logic              ovf_sticky,
  output logic [OVF_CW-1:0] ovf_cnt
);
  localparam int PW = 2 * DW;      // product width
  localparam int SW = 2 * DW + 1;  // product sum width
  localparam logic signed [SW-1:0] RND = SW'(1) << (FRAC - 1);

  // Stage registers
  logic [PW-1:0]        a1_q, b1_q, w1_q, a2_q, a3_q;
  logic                 byp1_q, scl1_q, scl2_q, scl3_q;
  logic                 v1_q, v2_q, v3_q, v4_q;
  logic signed [PW-1:0] rr2_q, ii2_q, ri2_q, ir2_q;
  logic signed [DW:0]   pr3_q, pi3_q;
  logic [PW-1:0]        x0_q, x1_q;
  logic                 sticky_q;
  logic [OVF_CW-1:0]    cnt_q;

  // Next-state values
  logic signed [PW-1:0] rr_d, ii_d, ri_d, ir_d;
  logic signed [DW:0]   pr_d, pi_d;
  logic [PW-1:0]        x0_d, x1_d;
  logic                 sticky_d;
  logic [OVF_CW-1:0]    cnt_d;
  logic                 any_sat;
  logic                 adv;

  // Whole pipeline moves together: only a held output blocks it.
  assign adv          = bus.out_ready | ~v4_q;
  assign bus.in_ready = adv;
  assign bus.out_valid = v4_q;
  assign bus.x0_out   = x0_q;
  assign bus.x1_out   = x1_q;
  assign ovf_sticky   = sticky_q;
  assign ovf_cnt      = cnt_q;

  // Clamp the rounded product to DW+1 bits (the headroom bit keeps A +/- P exact).
  function automatic logic signed [DW:0] sat_p(input logic signed [SW-1:0] v);
    if ((&v[SW-1:DW]) || (~|v[SW-1:DW]))
      return v[DW:0];
    else if (v[SW-1])
      return {1'b1, {DW{1'b0}}};
    else
      return {1'b0, {DW{1'b1}}};
  endfunction

  // Optional halving then clamp to DW bits; MSB of the result flags saturation.
  function automatic logic [DW:0] out_comp(input logic signed [DW+1:0] v, input logic scl);
    logic signed [DW+1:0] t;
    t = scl ? ((v + (DW+2)'(1)) >>> 1) : v;
    if ((&t[DW+1:DW-1]) || (~|t[DW+1:DW-1]))
      return {1'b0, t[DW-1:0]};
    else if (t[DW+1])
      return {1'b1, 1'b1, {(DW-1){1'b0}}};
    else
      return {1'b1, 1'b0, {(DW-1){1'b1}}};
  endfunction

  // S2: partial products. Bypass forces W = 1.0 by feeding B << FRAC straight
  // through the real/imaginary sums (ii and ri become zero).
  logic signed [DW-1:0] b_re, b_im, w_re, w_im;
  assign b_re = $signed(b1_q[PW-1:DW]);
  assign b_im = $signed(b1_q[DW-1:0]);
  assign w_re = $signed(w1_q[PW-1:DW]);
  assign w_im = $signed(w1_q[DW-1:0]);

  always_comb begin
    rr_d = PW'(b_re) * PW'(w_re);
    ii_d = PW'(b_im) * PW'(w_im);
    ri_d = PW'(b_re) * PW'(w_im);
    ir_d = PW'(b_im) * PW'(w_re);
    if (byp1_q) begin
      rr_d = PW'(b_re) <<< FRAC;
      ii_d = '0;
      ri_d = '0;
      ir_d = PW'(b_im) <<< FRAC;
    end
  end

  // S3: complex sum, round half up, clamp.
  logic signed [SW-1:0] pr_full, pi_full;
  always_comb begin
    pr_full = SW'(rr2_q) - SW'(ii2_q);
    pi_full = SW'(ri2_q) + SW'(ir2_q);
    pr_d    = sat_p((pr_full + RND) >>> FRAC);
    pi_d    = sat_p((pi_full + RND) >>> FRAC);
  end

  // S4: add/subtract against the delayed A, scale, saturate.
  logic signed [DW+1:0] a_re_x, a_im_x, p_re_x, p_im_x;
  logic [DW:0]          c0r, c0i, c1r, c1i;
  always_comb begin
    a_re_x  = {{2{a3_q[PW-1]}}, a3_q[PW-1:DW]};
    a_im_x  = {{2{a3_q[DW-1]}}, a3_q[DW-1:0]};
    p_re_x  = {pr3_q[DW], pr3_q};
    p_im_x  = {pi3_q[DW], pi3_q};
    c0r     = out_comp(a_re_x + p_re_x, scl3_q);
    c0i     = out_comp(a_im_x + p_im_x, scl3_q);
    c1r     = out_comp(a_re_x - p_re_x, scl3_q);
    c1i     = out_comp(a_im_x - p_im_x, scl3_q);
    any_sat = c0r[DW] | c0i[DW] | c1r[DW] | c1i[DW];
    x0_d    = {c0r[DW-1:0], c0i[DW-1:0]};
    x1_d    = {c1r[DW-1:0], c1i[DW-1:0]};
  end

  // Overflow bookkeeping: only a valid sample actually entering the output
  // register counts, and a clear in the same cycle wins.
  always_comb begin
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    if (ovf_clr) begin
      sticky_d = 1'b0;
      cnt_d    = '0;
    end else if (adv && v3_q && any_sat) begin
      sticky_d = 1'b1;
      if (cnt_q != {OVF_CW{1'b1}})
        cnt_d = cnt_q + OVF_CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      v4_q     <= 1'b0;
      x0_q     <= '0;
      x1_q     <= '0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (adv) begin
        a1_q   <= bus.a_in;
        b1_q   <= bus.b_in;
        w1_q   <= bus.w_in;
        byp1_q <= bus.bypass;
        scl1_q <= bus.scale;
        v1_q   <= bus.in_valid;
        a2_q   <= a1_q;
        rr2_q  <= rr_d;
        ii2_q  <= ii_d;
        ri2_q  <= ri_d;
        ir2_q  <= ir_d;
        scl2_q <= scl1_q;
        v2_q   <= v1_q;
        a3_q   <= a2_q;
        pr3_q  <= pr_d;
        pi3_q  <= pi_d;
        scl3_q <= scl2_q;
        v3_q   <= v2_q;
        x0_q   <= x0_d;
        x1_q   <= x1_d;
        v4_q   <= v3_q;
      end
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: tb/tb_fft_butterfly_pipe.sv
// tb/tb_fft_butterfly_pipe.sv - self-checking bench for fft_butterfly_pipe
module tb_fft_butterfly_pipe;
  logic       clk;
  logic       reset;
  logic       ovf_clr;
  logic       ovf_sticky;
  logic [7:0] ovf_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] x0;
    logic [31:0] x1;
    bit          ovf;
  } res_t;

  res_t exp_q[$];
  res_t obs_q[$];

  fft_butterfly_pipe_if #(.DW(16)) bus ();

  fft_butterfly_pipe #(.DW(16), .FRAC(8), .OVF_CW(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .ovf_clr   (ovf_clr),
    .ovf_sticky(ovf_sticky),
    .ovf_cnt   (ovf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk)
    if (!reset && bus.out_valid && bus.out_ready)
      obs_q.push_back('{bus.x0_out, bus.x1_out, 1'b0});

  // Reference: plain integer arithmetic on Q.8 values.
  function automatic res_t model(input logic [31:0] a, b, w, input bit byp, scl);
    longint ar, ai, br, bi, wr, wi, pr, pi;
    longint v[4];
    logic [15:0] o[4];
    res_t r;
    ar = longint'($signed(a[31:16])); ai = longint'($signed(a[15:0]));
    br = longint'($signed(b[31:16])); bi = longint'($signed(b[15:0]));
    wr = longint'($signed(w[31:16])); wi = longint'($signed(w[15:0]));
    if (byp) begin
      pr = br * 256; pi = bi * 256;
    end else begin
      pr = br * wr - bi * wi; pi = br * wi + bi * wr;
    end
    pr = (pr + 128) >>> 8; pi = (pi + 128) >>> 8;
    if (pr > 65535) pr = 65535; if (pr < -65536) pr = -65536;
    if (pi > 65535) pi = 65535; if (pi < -65536) pi = -65536;
    v[0] = ar + pr; v[1] = ai + pi; v[2] = ar - pr; v[3] = ai - pi;
    r.ovf = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (scl) v[k] = (v[k] + 1) >>> 1;
      if (v[k] > 32767) begin v[k] = 32767; r.ovf = 1'b1; end
      if (v[k] < -32768) begin v[k] = -32768; r.ovf = 1'b1; end
      o[k] = 16'(v[k]);
    end
    r.x0 = {o[0], o[1]};
    r.x1 = {o[2], o[3]};
    return r;
  endfunction

  function automatic logic [15:0] rnd16();
    logic [15:0] t;
    t = 16'($urandom);
    if ($urandom_range(0, 1) == 0) t = {{6{t[9]}}, t[9:0]};
    return t;
  endfunction

  task automatic send(input logic [31:0] a, b, w, input bit byp, scl);
    bit acc;
    int guard;
    acc = 1'b0; guard = 0;
    bus.in_valid = 1'b1; bus.a_in = a; bus.b_in = b; bus.w_in = w;
    bus.bypass = byp; bus.scale = scl;
    while (!acc && guard < 1000) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk); #1;
      guard++;
    end
    bus.in_valid = 1'b0;
    if (acc) exp_q.push_back(model(a, b, w, byp, scl));
    else begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: in_ready=0 required 1");
    end
  endtask

  task automatic wait_obs(input int n, output bit ok);
    for (int g = 0; g < 2000 && obs_q.size() < n; g++) begin
      @(posedge clk); #1;
    end
    ok = (obs_q.size() >= n);
  endtask

  task automatic pulse_clr();
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    n_checks++; if (bus.x0_out !== 32'h0) begin n_fail++; $display("FAIL rst_x0: got %h want 0", bus.x0_out); end
    n_checks++; if (bus.x1_out !== 32'h0) begin n_fail++; $display("FAIL rst_x1: got %h want 0", bus.x1_out); end
    n_checks++; if (ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL rst_sticky: got %b want 0", ovf_sticky); end
    n_checks++; if (ovf_cnt !== 8'h0) begin n_fail++; $display("FAIL rst_cnt: got %h want 0", ovf_cnt); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [31:0] va[7], vb[7], vw[7], ex0[7], ex1[7];
    bit vbyp[7], vscl[7];
    bit ok;
    int lat;
    va[0]=32'h01000000; vb[0]=32'h00800000; vw[0]=32'h01000000; vbyp[0]=0; vscl[0]=0; ex0[0]=32'h01800000; ex1[0]=32'h00800000;
    va[1]=32'h00000000; vb[1]=32'h01000000; vw[1]=32'h0000FF00; vbyp[1]=0; vscl[1]=0; ex0[1]=32'h0000FF00; ex1[1]=32'h00000100;
    va[2]=32'h00000000; vb[2]=32'h01000000; vw[2]=32'h0000FF00; vbyp[2]=1; vscl[2]=0; ex0[2]=32'h01000000; ex1[2]=32'hFF000000;
    va[3]=32'h00000000; vb[3]=32'h00010000; vw[3]=32'h00800000; vbyp[3]=0; vscl[3]=0; ex0[3]=32'h00010000; ex1[3]=32'hFFFF0000;
    va[4]=32'h00000000; vb[4]=32'hFFFF0000; vw[4]=32'h00800000; vbyp[4]=0; vscl[4]=0; ex0[4]=32'h00000000; ex1[4]=32'h00000000;
    va[5]=32'h7F000000; vb[5]=32'h7F000000; vw[5]=32'h01000000; vbyp[5]=0; vscl[5]=0; ex0[5]=32'h7FFF0000; ex1[5]=32'h00000000;
    va[6]=32'h7F000000; vb[6]=32'h7F000000; vw[6]=32'h01000000; vbyp[6]=0; vscl[6]=1; ex0[6]=32'h7F000000; ex1[6]=32'h00000000;
    obs_q.delete(); exp_q.delete();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      send(va[k], vb[k], vw[k], vbyp[k], vscl[k]);
      if (k == 0) begin
        lat = 1;
        while (!bus.out_valid && lat < 10) begin @(posedge clk); #1; lat++; end
        n_checks++; if (lat != 4) begin n_fail++; $display("FAIL latency: got %0d want 4", lat); end
      end
      wait_obs(k + 1, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL dir_timeout[%0d]: got %0d outputs want %0d", k, obs_q.size(), k + 1); end
      if (ok) begin
        n_checks++; if (obs_q[k].x0 !== ex0[k]) begin n_fail++; $display("FAIL dir_x0[%0d]: got %h want %h", k, obs_q[k].x0, ex0[k]); end
        n_checks++; if (obs_q[k].x1 !== ex1[k]) begin n_fail++; $display("FAIL dir_x1[%0d]: got %h want %h", k, obs_q[k].x1, ex1[k]); end
      end
      if (k == 4) begin
        n_checks++; if (ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL dir_no_ovf: sticky %b want 0", ovf_sticky); end
      end
      @(posedge clk); #1;
    end
    n_checks++; if (ovf_sticky !== 1'b1) begin n_fail++; $display("FAIL dir_sticky: got %b want 1", ovf_sticky); end
    n_checks++; if (ovf_cnt !== 8'd1) begin n_fail++; $display("FAIL dir_cnt: got %0d want 1", ovf_cnt); end
  endtask

  task automatic test_ovf_clr();
    pulse_clr();
    n_checks++; if (ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL clr_sticky: got %b want 0", ovf_sticky); end
    n_checks++; if (ovf_cnt !== 8'd0) begin n_fail++; $display("FAIL clr_cnt: got %0d want 0", ovf_cnt); end
  endtask

  task automatic test_stall();
    logic [31:0] hx0, hx1;
    obs_q.delete(); exp_q.delete();
    fork
      begin
        for (int i = 0; i < 8; i++)
          send({rnd16(), rnd16()}, {rnd16(), rnd16()}, {rnd16(), rnd16()}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      begin
        for (int c = 0; c < 40; c++) begin
          bus.out_ready = !(c >= 5 && c <= 7);
          @(negedge clk);
          if (c >= 5 && c <= 7) begin
            n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready[c%0d]: got %b want 0", c, bus.in_ready); end
            n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_out_valid[c%0d]: got %b want 1", c, bus.out_valid); end
            if (c == 5) begin hx0 = bus.x0_out; hx1 = bus.x1_out; end
            else begin
              n_checks++; if (bus.x0_out !== hx0 || bus.x1_out !== hx1) begin n_fail++; $display("FAIL stall_hold[c%0d]: got %h/%h want %h/%h", c, bus.x0_out, bus.x1_out, hx0, hx1); end
            end
          end
          @(posedge clk); #1;
        end
      end
    join
    n_checks++; if (obs_q.size() != 8) begin n_fail++; $display("FAIL stall_count: got %0d want 8", obs_q.size()); end
    for (int i = 0; i < 8 && i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (obs_q[i].x0 !== exp_q[i].x0 || obs_q[i].x1 !== exp_q[i].x1) begin
        n_fail++; $display("FAIL stall_data[%0d]: got %h/%h want %h/%h", i, obs_q[i].x0, obs_q[i].x1, exp_q[i].x0, exp_q[i].x1);
      end
    end
  endtask

  task automatic test_random();
    bit drv_done, ok;
    int n_ovf, want_cnt;
    obs_q.delete(); exp_q.delete();
    bus.out_ready = 1'b1;
    pulse_clr();
    n_checks++; if (ovf_cnt !== 8'd0) begin n_fail++; $display("FAIL rnd_clr_cnt: got %0d want 0", ovf_cnt); end
    drv_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          send({rnd16(), rnd16()}, {rnd16(), rnd16()}, {rnd16(), rnd16()}, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          bus.out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    wait_obs(60, ok);
    n_checks++; if (!ok || obs_q.size() != 60) begin n_fail++; $display("FAIL rnd_count: got %0d want 60", obs_q.size()); end
    n_ovf = 0;
    for (int i = 0; i < exp_q.size(); i++) if (exp_q[i].ovf) n_ovf++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (obs_q[i].x0 !== exp_q[i].x0 || obs_q[i].x1 !== exp_q[i].x1) begin
        n_fail++; $display("FAIL rnd_data[%0d]: got %h/%h want %h/%h", i, obs_q[i].x0, obs_q[i].x1, exp_q[i].x0, exp_q[i].x1);
      end
    end
    want_cnt = (n_ovf > 255) ? 255 : n_ovf;
    n_checks++; if (ovf_cnt !== 8'(want_cnt)) begin n_fail++; $display("FAIL rnd_cnt: got %0d want %0d", ovf_cnt, want_cnt); end
    n_checks++; if (ovf_sticky !== (n_ovf > 0)) begin n_fail++; $display("FAIL rnd_sticky: got %b want %b", ovf_sticky, n_ovf > 0); end
  endtask

  task automatic test_cnt_saturate();
    bit ok;
    int n_ovf;
    obs_q.delete(); exp_q.delete();
    bus.out_ready = 1'b1;
    pulse_clr();
    for (int i = 0; i < 260; i++) send(32'h7F000000, 32'h7F000000, 32'h01000000, 1'b0, 1'b0);
    wait_obs(260, ok);
    n_ovf = 0;
    for (int i = 0; i < exp_q.size(); i++) if (exp_q[i].ovf) n_ovf++;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL sat_count: got %0d want 260", obs_q.size()); end
    n_checks++; if (ovf_cnt !== 8'((n_ovf > 255) ? 255 : n_ovf)) begin n_fail++; $display("FAIL sat_cnt: got %0d want %0d", ovf_cnt, (n_ovf > 255) ? 255 : n_ovf); end
    n_checks++; if (ovf_sticky !== 1'b1) begin n_fail++; $display("FAIL sat_sticky: got %b want 1", ovf_sticky); end
  endtask

  task automatic test_reset_midstream();
    obs_q.delete(); exp_q.delete();
    pulse_clr();
    bus.out_ready = 1'b0;
    send(32'h7F000000, 32'h7F000000, 32'h01000000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send(32'h00100000, 32'h00200000, 32'h01000000, 1'b0, 1'b0);
    n_checks++; if (ovf_sticky !== 1'b1 || ovf_cnt !== 8'd1) begin n_fail++; $display("FAIL mid_pre_ovf: got %b/%0d want 1/1", ovf_sticky, ovf_cnt); end
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: got %b want 1", bus.out_valid); end
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid: got %b want 0", bus.out_valid); end
    n_checks++; if (ovf_sticky !== 1'b0 || ovf_cnt !== 8'd0) begin n_fail++; $display("FAIL mid_ovf: got %b/%0d want 0/0", ovf_sticky, ovf_cnt); end
    reset = 1'b0;
    bus.out_ready = 1'b1;
    exp_q.delete();
    repeat (20) begin @(posedge clk); #1; end
    n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL mid_stale: got %0d outputs want 0", obs_q.size()); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_clr_priority();
    bit ok;
    obs_q.delete(); exp_q.delete();
    bus.out_ready = 1'b1;
    send(32'h7F000000, 32'h7F000000, 32'h01000000, 1'b0, 1'b0);
    wait_obs(1, ok);
    n_checks++; if (!ok || ovf_cnt !== 8'd1) begin n_fail++; $display("FAIL prio_pre_cnt: got %0d want 1", ovf_cnt); end
    @(posedge clk); #1;
    send(32'h7F000000, 32'h7F000000, 32'h01000000, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL prio_valid: got %b want 1", bus.out_valid); end
    n_checks++; if (ovf_cnt !== 8'd0) begin n_fail++; $display("FAIL prio_cnt: got %0d want 0", ovf_cnt); end
    n_checks++; if (ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL prio_sticky: got %b want 0", ovf_sticky); end
  endtask

  initial begin
    reset = 1'b1; ovf_clr = 1'b0;
    bus.in_valid = 1'b0; bus.a_in = '0; bus.b_in = '0; bus.w_in = '0;
    bus.bypass = 1'b0; bus.scale = 1'b0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    test_reset();
    test_directed();
    test_ovf_clr();
    test_stall();
    test_random();
    test_cnt_saturate();
    test_reset_midstream();
    test_clr_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
